// File: rtl/decode2_4_seq.sv
// decode2_4_seq: buffered 2-to-4 decoder. Encoded {en, code} symbols queue in
// a DEPTH-entry FIFO and are expanded into a registered one-hot word on a
// valid/ready output stream. Total buffering is DEPTH+1 symbols.
// Optional per-code hit counters are enabled by defining DECODE2_4_SEQ_STATS_EN.
module decode2_4_seq #(
  parameter int DEPTH = 4
`ifdef DECODE2_4_SEQ_STATS_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1:0]                   in_code,
  input  logic                         in_en,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [3:0]                   out_onehot,
  output logic [$clog2(DEPTH+2)-1:0]   level
`ifdef DECODE2_4_SEQ_STATS_EN
  ,
  input  logic                         stats_clr,
  output logic [4*CNT_W-1:0]           hit_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = $clog2(DEPTH + 2);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t        state;
  state_t        next_state;
  logic [2:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic [2:0]    head;

  // Full/empty comes from the separate count so pointers can wrap freely.
  assign in_ready  = (count != CW'(DEPTH));
  assign push      = in_valid && in_ready;
  assign head      = mem[rd_ptr];
  assign out_valid = (state == FULL);
  assign level     = LW'(count) + LW'(state == FULL);

  // Storage array: written on push only, no reset needed for the data.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_en, in_code};
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Output stage state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= next_state;
    end
  end

  // Output stage next-state: refill the register whenever it is empty or drained.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      EMPTY: begin
        if (count != '0) begin
          pop        = 1'b1;
          next_state = FULL;
        end
      end
      FULL: begin
        if (out_ready) begin
          if (count != '0) begin
            pop = 1'b1;
          end else begin
            next_state = EMPTY;
          end
        end
      end
      default: next_state = EMPTY;
    endcase
  end

  // Decode the FIFO head into the one-hot register when it is loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_onehot <= 4'b0000;
    end else if (pop) begin
      out_onehot <= head[2] ? (4'b0001 << head[1:0]) : 4'b0000;
    end
  end

`ifdef DECODE2_4_SEQ_STATS_EN
  logic [CNT_W-1:0] hits [4];

  // Saturating hit counters per delivered non-zero word; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) hits[k] <= '0;
    end else if (stats_clr) begin
      for (int k = 0; k < 4; k++) hits[k] <= '0;
    end else if (out_valid && out_ready) begin
      for (int k = 0; k < 4; k++) begin
        if (out_onehot[k] && (hits[k] != {CNT_W{1'b1}})) begin
          hits[k] <= hits[k] + 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_pack
    assign hit_cnt[g*CNT_W +: CNT_W] = hits[g];
  end
`endif

endmodule
